if_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline, sitting directly upstream of the IF/ID register. Owns the fetch PC and issues in-order requests to instruction memory over a request/grant + response handshake. Buffers returned words in a 2-entry queue and presents `pc`/`npc`/`instr` with a valid flag to IF/ID. Honours the hazard unit's stall and EX-stage redirects (branch/jump), discarding stale in-flight responses.

---
 rtl/if_fetch.sv | 137 +++++++++++++
 tb/tb_if_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - RISC-V instruction-fetch stage with 2-credit request window and 2-entry output queue
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   stall                    IF/ID stall: hold queue head, no pop
//   redirect_valid/_pc       EX-stage redirect (highest priority below rst)
//   imem_req/_addr/_gnt      instruction memory request channel (req & gnt = accepted)
//   imem_rvalid/_rdata       in-order instruction memory responses
//   if_valid, pc, npc, instr queue head presented to IF/ID (pc/npc=0, instr=NOP when invalid)

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [31:0] instr
);

    localparam logic [31:0] NOP = 32'h0000_0033;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inf_pc_q [2];
    logic [31:0] inf_pc_d [2];
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  drop_cnt_q, drop_cnt_d;
    logic [31:0] q_pc_q [2];
    logic [31:0] q_pc_d [2];
    logic [31:0] q_instr_q [2];
    logic [31:0] q_instr_d [2];
    logic [1:0]  q_count_q, q_count_d;

    logic [2:0]  credit_used;
    logic        grant;
    logic        resp;
    logic        drop;
    logic        keep;
    logic        pop;
    logic [1:0]  live;
    logic        inf_wr_idx;
    logic        q_wr_idx;

    // Head decode: outputs come only from registered queue state.
    assign if_valid  = (q_count_q != 2'd0);
    assign pc        = if_valid ? q_pc_q[0] : 32'h0;
    assign npc       = if_valid ? (q_pc_q[0] + 32'd4) : 32'h0;
    assign instr     = if_valid ? q_instr_q[0] : NOP;
    assign imem_addr = fetch_pc_q;

    always_comb begin
        credit_used = {1'b0, outstanding_q} + {1'b0, q_count_q};
        imem_req    = !rst && !redirect_valid && (credit_used < 3'd2);
        grant       = imem_req && imem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp        = imem_rvalid && (outstanding_q != 2'd0);
        drop        = resp && (drop_cnt_q != 2'd0);
        keep        = resp && !drop;
        pop         = if_valid && !stall && !redirect_valid;
        // Live (non-stale) requests sit at the front of the in-flight FIFO.
        live        = outstanding_q - drop_cnt_q;
        // A grant implies live <= 1 and a kept response implies q_count <= 1,
        // so a single index bit suffices for both write slots.
        inf_wr_idx  = (live != 2'd0) && !keep;
        q_wr_idx    = (q_count_q != 2'd0) && !pop;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inf_pc_d      = inf_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        q_pc_d        = q_pc_q;
        q_instr_d     = q_instr_q;
        q_count_d     = q_count_q;

        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc & 32'hFFFF_FFFC;
            // Every request still pending after this cycle becomes stale;
            // a response arriving now is simply discarded.
            outstanding_d = outstanding_q - {1'b0, resp};
            drop_cnt_d    = outstanding_q - {1'b0, resp};
            q_count_d     = 2'd0;
        end else begin
            outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, resp};
            drop_cnt_d    = drop_cnt_q - {1'b0, drop};

            if (keep) begin
                inf_pc_d[0] = inf_pc_q[1];
            end
            if (grant) begin
                inf_pc_d[inf_wr_idx] = fetch_pc_q;
                fetch_pc_d           = fetch_pc_q + 32'd4;
            end

            if (pop) begin
                q_pc_d[0]    = q_pc_q[1];
                q_instr_d[0] = q_instr_q[1];
            end
            if (keep) begin
                q_pc_d[q_wr_idx]    = inf_pc_q[0];
                q_instr_d[q_wr_idx] = imem_rdata;
            end
            q_count_d = q_count_q - {1'b0, pop} + {1'b0, keep};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inf_pc_q      <= '{default: 32'h0};
            outstanding_q <= 2'd0;
            drop_cnt_q    <= 2'd0;
            q_pc_q        <= '{default: 32'h0};
            q_instr_q     <= '{default: 32'h0};
            q_count_q     <= 2'd0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inf_pc_q      <= inf_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            q_pc_q        <= q_pc_d;
            q_instr_q     <= q_instr_d;
            q_count_q     <= q_count_d;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch: directed table, corner sequences, random run vs queue model

module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0033;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .pc             (pc),
        .npc            (npc),
        .instr          (instr)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc(input logic [31:0] a);
        return a ^ 32'h5A00_00A5;
    endfunction

    // Reference model: in-flight requests as a queue tagged stale/live,
    // output queue of {pc, instr}, credit = in-flight + queued.
    typedef struct { logic [31:0] pc; bit stale; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    typedef struct { logic [31:0] addr; int ready; } mreq_t;

    pend_t       m_pend[$];
    ent_t        m_outq[$];
    logic [31:0] m_fpc;
    mreq_t       mq[$];

    int lat_min   = 1;
    int lat_max   = 1;
    int gnt_pct   = 100;
    int stall_pct = 0;
    bit stall_fix = 1'b0;
    int redir_pct = 0;
    int rst_pm    = 0;
    bit rst_fix   = 1'b0;
    bit granted_last;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } tvec_t;

    tvec_t tbl[13];
    tvec_t cur;
    bit    tbl_en = 1'b0;

    function automatic tvec_t mk(input bit r, input bit s, input bit q, input logic [31:0] a,
                                 input bit v, input logic [31:0] p);
        tvec_t t;
        t.rst = r; t.stall = s; t.req = q; t.addr = a; t.valid = v; t.pc = p;
        return t;
    endfunction

    task automatic model_reset();
        m_pend.delete();
        m_outq.delete();
        m_fpc = RESET_PC;
        mq.delete();
    endtask

    task automatic drive();
        rst            = rst_fix || (int'($urandom_range(999, 0)) < rst_pm);
        stall          = stall_fix || (int'($urandom_range(99, 0)) < stall_pct);
        redirect_valid = (int'($urandom_range(99, 0)) < redir_pct);
        redirect_pc    = $urandom;
        imem_gnt       = (int'($urandom_range(99, 0)) < gnt_pct);
        imem_rvalid    = (mq.size() > 0) && (mq[0].ready <= cyc);
        imem_rdata     = imem_rvalid ? enc(mq[0].addr) : $urandom;
    endtask

    task automatic step();
        bit    m_req;
        bit    m_valid;
        bit    resp;
        pend_t e;
        @(negedge clk);
        m_req   = !rst && !redirect_valid && ((m_pend.size() + m_outq.size()) < 2);
        m_valid = m_outq.size() > 0;
        check32("imem_req", imem_req, m_req);
        check32("imem_addr", imem_addr, m_fpc);
        check32("if_valid", if_valid, m_valid);
        check32("pc", pc, m_valid ? m_outq[0].pc : 32'h0);
        check32("npc", npc, m_valid ? m_outq[0].pc + 32'd4 : 32'h0);
        check32("instr", instr, m_valid ? m_outq[0].ins : NOP);
        if (tbl_en) begin
            check32("tbl_req", imem_req, cur.req);
            check32("tbl_addr", imem_addr, cur.addr);
            check32("tbl_valid", if_valid, cur.valid);
            check32("tbl_pc", pc, cur.valid ? cur.pc : 32'h0);
            check32("tbl_npc", npc, cur.valid ? cur.pc + 32'd4 : 32'h0);
            check32("tbl_instr", instr, cur.valid ? enc(cur.pc) : NOP);
        end
        granted_last = imem_req && imem_gnt;
        if (rst) begin
            model_reset();
        end else begin
            resp = imem_rvalid && (m_pend.size() > 0);
            if (resp) e = m_pend.pop_front();
            if (redirect_valid) begin
                foreach (m_pend[i]) m_pend[i].stale = 1'b1;
                m_outq.delete();
                m_fpc = redirect_pc & ~32'h3;
            end else begin
                if (m_valid && !stall) void'(m_outq.pop_front());
                if (resp && !e.stale) m_outq.push_back('{e.pc, imem_rdata});
                if (m_req && imem_gnt) begin
                    m_pend.push_back('{m_fpc, 1'b0});
                    m_fpc = m_fpc + 32'd4;
                end
            end
            if (imem_rvalid) void'(mq.pop_front());
            if (imem_req && imem_gnt)
                mq.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    initial begin
        bit found;

        // Zero-wait memory from reset, with a 3-cycle stall while pc=8 is at the head.
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 32'd4,  1'b0, 32'd0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 32'd8,  1'b1, 32'd0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, 32'd8,  1'b1, 32'd4);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 32'd12, 1'b0, 32'd0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd8);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'd8);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 32'd16, 1'b1, 32'd12);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 32'd20, 1'b0, 32'd0);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'd24, 1'b1, 32'd16);

        rst_fix = 1'b1;
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_fix = 1'b0;
        drive();

        tbl_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cur   = tbl[i];
            rst   = tbl[i].rst;
            stall = tbl[i].stall;
            step();
        end
        tbl_en = 1'b0;

        // Address wrap with grant held off.
        gnt_pct        = 0;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        for (int i = 0; i < 4; i++) begin
            #2;
            check32("wrap_hold_addr", imem_addr, 32'hFFFF_FFFC);
            step();
        end
        gnt_pct = 100;
        found   = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (granted_last) found = 1'b1;
        end
        check32("wrap_grant_seen", found, 1'b1);
        #2;
        check32("wrap_next_addr", imem_addr, 32'h0000_0000);
        repeat (6) step();

        // Redirect to 0x103 with two requests in flight, latency 3.
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_pend.size() == 2) found = 1'b1;
            else step();
        end
        check32("redir_two_inflight", found, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        #2;
        check32("redir_r1_valid", if_valid, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            #2;
            if (if_valid) begin
                found = 1'b1;
                check32("redir_first_pc", pc, 32'h0000_0100);
                check32("redir_first_npc", npc, 32'h0000_0104);
            end
        end
        check32("redir_target_seen", found, 1'b1);

        // Redirect in the same cycle as a response and a stall.
        lat_min = 1;
        lat_max = 2;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (imem_rvalid) begin
                found          = 1'b1;
                redirect_valid = 1'b1;
                stall          = 1'b1;
                redirect_pc    = 32'h0000_0200;
                step();
                #2;
                check32("redir_rv_valid", if_valid, 1'b0);
                check32("redir_rv_instr", instr, NOP);
                check32("redir_rv_pc", pc, 32'h0);
            end
        end
        check32("redir_rv_seen", found, 1'b1);

        // Reset with the output queue full.
        lat_min   = 1;
        lat_max   = 1;
        stall_fix = 1'b1;
        stall     = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_outq.size() == 2) found = 1'b1;
            else step();
        end
        check32("rst_queue_full", found, 1'b1);
        rst_fix = 1'b1;
        rst     = 1'b1;
        step();
        #2;
        check32("rst_valid", if_valid, 1'b0);
        check32("rst_pc", pc, 32'h0);
        check32("rst_npc", npc, 32'h0);
        check32("rst_instr", instr, NOP);
        check32("rst_req", imem_req, 1'b0);
        step();
        rst_fix   = 1'b0;
        stall_fix = 1'b0;
        rst       = 1'b0;
        stall     = 1'b0;
        #2;
        check32("rst_restart_req", imem_req, 1'b1);
        check32("rst_restart_addr", imem_addr, RESET_PC);
        repeat (5) step();

        // Random traffic against the model.
        lat_min   = 1;
        lat_max   = 4;
        gnt_pct   = 70;
        stall_pct = 25;
        redir_pct = 5;
        rst_pm    = 5;
        repeat (3000) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
